led_fader: RTL and testbench
============================

LED_FADER -- requirements
Module: led_fader

Upstream brightness sequencer that produces the 15-bit duty value consumed by the RGB-LED PWM stage.

Interface -- parameters
REQ-001 SHALL have parameter TICK_DIV, default 32'h10000, giving clock cycles per ramp update; this matches the default PWM period.
REQ-002 SHALL have parameter STEP, default 15'd64, giving the duty increment/decrement applied per update.
REQ-003 SHALL have parameter MAX_HIGH, default 15'h7FFF, giving the ceiling applied to every accepted target.

Interface -- ports
REQ-004 SHALL have clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have cmd_valid, input, 1 bit: command offered.
REQ-007 SHALL have cmd_ready, output, 1 bit: command can be accepted this cycle.
REQ-008 SHALL have cmd_target, input, 15 bits: requested duty.
REQ-009 SHALL have cmd_mode, input, 2 bits: 00 SET, 01 RAMP, 10 BREATHE, 11 reserved.
REQ-010 SHALL have n_high, output, 15 bits, registered: duty value fed to the PWM stage.
REQ-011 SHALL have busy, output, 1 bit: high while state is not IDLE.
REQ-012 SHALL have done, output, 1 bit: single-cycle pulse when a SET or RAMP command completes.

Function
REQ-013 SHALL accept a command on any rising edge where cmd_valid and cmd_ready are both 1; no other edge accepts a command.
REQ-014 SHALL clamp the accepted target: tgt = min(cmd_target, MAX_HIGH).
REQ-015 SHALL run a free-running tick counter over 0..TICK_DIV-1 that commands never reset; tick = 1 exactly in the cycle where the counter equals TICK_DIV-1.
REQ-016 SHALL implement the state machine IDLE, RAMP, BR_UP, BR_DOWN.
REQ-017 SHALL drive cmd_ready = 1 in IDLE, BR_UP and BR_DOWN, and cmd_ready = 0 in RAMP.
REQ-018 SHALL handle SET accepted in any state as follows: n_high = tgt on the next edge, done = 1 in that same next cycle, state goes to IDLE.
REQ-019 SHALL handle RAMP accepted as follows: if tgt equals n_high, next-cycle done pulse and stay IDLE; otherwise go to RAMP.
REQ-020 SHALL, in RAMP, change n_high only on tick edges: up gives min(n_high+STEP, tgt), down gives max(n_high-STEP, tgt).
REQ-021 SHALL compute ramp arithmetic at 16 bits so nothing wraps.
REQ-022 SHALL, on the tick edge where n_high reaches tgt in RAMP, go to IDLE with done = 1 in the following cycle.
REQ-023 SHALL handle BREATHE accepted as follows: latch tgt, go to BR_UP, and keep n_high at its current value with no jump.
REQ-024 SHALL, in BR_UP, step toward tgt on each tick; reaching tgt goes to BR_DOWN.
REQ-025 SHALL, in BR_DOWN, step toward 0 on each tick; reaching 0 goes to BR_UP.
REQ-026 SHALL handle n_high above tgt in BR_UP by stepping down to tgt first.
REQ-027 SHALL, for BREATHE with tgt = 0, hold n_high at 0 and alternate BR_UP/BR_DOWN on every tick.
REQ-028 SHALL never assert done in breathe states.
REQ-029 SHALL let a new command accepted in BR_UP/BR_DOWN take effect immediately, with a tick in the same cycle ignored.
REQ-030 SHALL ignore mode 11: accepted and dropped, state and n_high unchanged, no done.
REQ-031 SHALL keep n_high within 0..MAX_HIGH at all times.

Reset
REQ-032 SHALL, on rst_n = 0, asynchronously force: n_high = 0, state = IDLE, busy = 0, done = 0, tick counter = 0, latched target = 0.
REQ-033 SHALL drive cmd_ready = 1 while in reset.
REQ-034 SHALL resume on the first rising edge after rst_n deasserts, with no extra wait.
REQ-035 SHALL, on reset mid-RAMP or mid-breathe, abandon the operation with no done pulse.

Verification
REQ-036 SHALL cover SET with tgt 0x1234 from reset, giving n_high = 0x1234 and a done pulse one cycle after acceptance.
REQ-037 SHALL cover RAMP 0->35 with TICK_DIV=4 and STEP=10: n_high 10,20,30,35 on successive ticks, then done, with cmd_ready = 0 throughout.
REQ-038 SHALL cover a RAMP down from 0x7FF0 to 0x0005 with STEP=0x7000, giving n_high 0x0FF0 then 0x0005 with no wrap.
REQ-039 SHALL cover BREATHE tgt=20 with STEP=10: n_high sequence 10,20,10,0,10,... with busy = 1 and done never asserted; then SET 5 mid-breathe gives n_high = 5 and IDLE next cycle.
REQ-040 SHALL cover cmd_target 0x7FFF with MAX_HIGH=0x1000, where SET yields 0x1000.
REQ-041 SHALL cover rst_n pulsed low mid-RAMP, giving immediate n_high = 0, busy = 0, no done, and the tick counter restarting from 0.

Source files
------------

// File: rtl/led_fader_if.sv
// Command channel into the LED brightness sequencer.
// Single-cycle valid/ready handshake; one command per accepting edge.
// The master holds cmd_valid/cmd_target/cmd_mode until it sees cmd_ready.
//
// cmd_valid  : command offered
// cmd_ready  : sequencer can take a command this cycle
// cmd_target : requested duty (15 bits)
// cmd_mode   : 00 SET, 01 RAMP, 10 BREATHE, 11 reserved
interface led_fader_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [14:0] cmd_target;
    logic [1:0]  cmd_mode;

    modport master (
        output cmd_valid,
        output cmd_target,
        output cmd_mode,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target,
        input  cmd_mode,
        output cmd_ready
    );
endinterface

// File: rtl/led_fader.sv
// Brightness sequencer producing the 15-bit duty word for the PWM stage.
// Latency: SET lands on n_high one edge after acceptance; ramps move once per tick.
// Backpressure: cmd_ready drops only while a RAMP is in progress.
//
// Ports:
//   clk    : single rising-edge clock
//   rst_n  : asynchronous active-low reset
//   cmd    : command channel (slave side of led_fader_if)
//   n_high : registered duty value, always within 0..MAX_HIGH
//   busy   : high whenever a ramp or breathe cycle is running
//   done   : one-cycle pulse after a SET or RAMP completes
module led_fader #(
    parameter logic [31:0] TICK_DIV = 32'h10000,
    parameter logic [14:0] STEP     = 15'd64,
    parameter logic [14:0] MAX_HIGH = 15'h7FFF
) (
    input  logic        clk,
    input  logic        rst_n,
    led_fader_if.slave  cmd,
    output logic [14:0] n_high,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP    = 2'd1,
        BR_UP   = 2'd2,
        BR_DOWN = 2'd3
    } state_t;

    localparam logic [1:0] MODE_SET     = 2'b00;
    localparam logic [1:0] MODE_RAMP    = 2'b01;
    localparam logic [1:0] MODE_BREATHE = 2'b10;

    state_t      state, state_d;
    logic [14:0] n_high_d;
    logic [14:0] tgt_q, tgt_d;
    logic        done_d;
    logic [31:0] tick_cnt;
    logic        tick;
    logic        accept;
    logic [14:0] tgt_in;
    logic [14:0] step_to_tgt;
    logic [14:0] step_to_zero;

    // Free-running update strobe; commands never disturb its phase.
    assign tick = (tick_cnt == TICK_DIV - 32'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= 32'd0;
        end else if (tick) begin
            tick_cnt <= 32'd0;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

    // One STEP toward dst without overshoot. Compared at 16 bits so that
    // cur+STEP and dst+STEP cannot wrap for any 15-bit operands.
    function automatic logic [14:0] step_toward(input logic [14:0] cur,
                                                input logic [14:0] dst);
        logic [15:0] cur_w;
        logic [15:0] dst_w;
        logic [15:0] step_w;
        logic [14:0] res;
        cur_w  = {1'b0, cur};
        dst_w  = {1'b0, dst};
        step_w = {1'b0, STEP};
        if (cur_w < dst_w) begin
            if (cur_w + step_w >= dst_w) res = dst;
            else                         res = cur + STEP;
        end else begin
            if (cur_w <= dst_w + step_w) res = dst;
            else                         res = cur - STEP;
        end
        return res;
    endfunction

    assign cmd.cmd_ready = (state != RAMP);
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign tgt_in        = (cmd.cmd_target > MAX_HIGH) ? MAX_HIGH : cmd.cmd_target;
    assign step_to_tgt   = step_toward(n_high, tgt_q);
    assign step_to_zero  = step_toward(n_high, 15'd0);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            n_high <= 15'd0;
            tgt_q  <= 15'd0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            n_high <= n_high_d;
            tgt_q  <= tgt_d;
            done   <= done_d;
        end
    end

    // An accepted command always wins over a coincident tick, so a command
    // issued during breathe takes effect immediately.
    always_comb begin
        state_d  = state;
        n_high_d = n_high;
        tgt_d    = tgt_q;
        done_d   = 1'b0;
        if (accept) begin
            case (cmd.cmd_mode)
                MODE_SET: begin
                    n_high_d = tgt_in;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
                MODE_RAMP: begin
                    tgt_d = tgt_in;
                    if (tgt_in == n_high) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = RAMP;
                    end
                end
                MODE_BREATHE: begin
                    // Start from the current level; no jump.
                    tgt_d   = tgt_in;
                    state_d = BR_UP;
                end
                default: begin
                    // Reserved mode: consumed and dropped.
                end
            endcase
        end else if (tick) begin
            case (state)
                RAMP: begin
                    n_high_d = step_to_tgt;
                    if (step_to_tgt == tgt_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
                BR_UP: begin
                    // Also handles a start level above the target by walking down.
                    n_high_d = step_to_tgt;
                    if (step_to_tgt == tgt_q) state_d = BR_DOWN;
                end
                BR_DOWN: begin
                    n_high_d = step_to_zero;
                    if (step_to_zero == 15'd0) state_d = BR_UP;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_fader.sv
module tb_led_fader;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    led_fader_if ifa ();
    led_fader_if ifb ();
    led_fader_if ifc ();

    logic [14:0] n_a, n_b, n_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;

    led_fader #(.TICK_DIV(32'd4), .STEP(15'd10), .MAX_HIGH(15'h7FFF)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd(ifa), .n_high(n_a), .busy(busy_a), .done(done_a));
    led_fader #(.TICK_DIV(32'd4), .STEP(15'h7000), .MAX_HIGH(15'h7FFF)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd(ifb), .n_high(n_b), .busy(busy_b), .done(done_b));
    led_fader #(.TICK_DIV(32'd4), .STEP(15'd10), .MAX_HIGH(15'h1000)) dut_c (
        .clk(clk), .rst_n(rst_n), .cmd(ifc), .n_high(n_c), .busy(busy_c), .done(done_c));

    int n_cmp = 0;
    int n_bad = 0;

    // Reference for dut_a: level/target as plain integers, activity as
    // 0 idle, 1 ramping, 2 breathing toward target, 3 breathing toward zero.
    int          m_level, m_tgt, m_act, m_done;
    int unsigned k;   // rising edges since reset release

    function automatic int toward(input int cur, input int dst);
        if (cur < dst) return (cur + 10 > dst) ? dst : cur + 10;
        else           return (cur - 10 < dst) ? dst : cur - 10;
    endfunction

    task automatic model_reset();
        m_level = 0; m_tgt = 0; m_act = 0; m_done = 0; k = 0;
    endtask

    task automatic model_edge(input bit v, input int t, input int m);
        bit acc;
        int tc;
        acc    = v && (m_act != 1);
        tc     = (t > 32767) ? 32767 : t;
        m_done = 0;
        if (acc) begin
            if (m == 0) begin
                m_level = tc; m_done = 1; m_act = 0;
            end else if (m == 1) begin
                m_tgt = tc;
                if (tc == m_level) begin m_done = 1; m_act = 0; end
                else m_act = 1;
            end else if (m == 2) begin
                m_tgt = tc; m_act = 2;
            end
        end else if ((k % 4) == 3) begin
            if (m_act == 1) begin
                m_level = toward(m_level, m_tgt);
                if (m_level == m_tgt) begin m_act = 0; m_done = 1; end
            end else if (m_act == 2) begin
                m_level = toward(m_level, m_tgt);
                if (m_level == m_tgt) m_act = 3;
            end else if (m_act == 3) begin
                m_level = toward(m_level, 0);
                if (m_level == 0) m_act = 2;
            end
        end
        k++;
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic cycle(input int sel, input bit v, input int t, input int m);
        logic [14:0] tv;
        logic [1:0]  mv;
        tv = t[14:0];
        mv = m[1:0];
        ifa.cmd_valid = (sel == 0) && v;
        ifb.cmd_valid = (sel == 1) && v;
        ifc.cmd_valid = (sel == 2) && v;
        ifa.cmd_target = tv; ifb.cmd_target = tv; ifc.cmd_target = tv;
        ifa.cmd_mode   = mv; ifb.cmd_mode   = mv; ifc.cmd_mode   = mv;
        model_edge((sel == 0) && v, t, m);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ifa.cmd_valid = 1'b0; ifb.cmd_valid = 1'b0; ifc.cmd_valid = 1'b0;
        ifa.cmd_target = '0;  ifb.cmd_target = '0;  ifc.cmd_target = '0;
        ifa.cmd_mode = '0;    ifb.cmd_mode = '0;    ifc.cmd_mode = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(negedge clk);
        n_cmp++; if (n_a !== 15'd0)   begin n_bad++; $display("FAIL reset_n_high: got %0h want 0", n_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_a); end
        n_cmp++; if (ifa.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ifa.cmd_ready); end
        rst_n = 1'b1;
    endtask

    task automatic test_set();
        do_reset();
        cycle(0, 1, 'h1234, 0);
        n_cmp++; if (n_a !== 15'h1234) begin n_bad++; $display("FAIL set_value: got %0h want 1234", n_a); end
        n_cmp++; if (done_a !== 1'b1)  begin n_bad++; $display("FAIL set_done: got %b want 1", done_a); end
        n_cmp++; if (busy_a !== 1'b0)  begin n_bad++; $display("FAIL set_busy: got %b want 0", busy_a); end
        cycle(0, 0, 0, 0);
        n_cmp++; if (done_a !== 1'b0)  begin n_bad++; $display("FAIL set_done_pulse: got %b want 0", done_a); end
    endtask

    task automatic test_ramp();
        int exp_v[4] = '{10, 20, 30, 35};
        int seen[$];
        int iters;
        logic [14:0] last;
        do_reset();
        cycle(0, 1, 35, 1);
        iters = 0;
        while (busy_a && iters < 40) begin
            n_cmp++; if (ifa.cmd_ready !== 1'b0) begin n_bad++; $display("FAIL ramp_ready: got %b want 0", ifa.cmd_ready); end
            last = n_a;
            cycle(0, 0, 0, 0);
            iters++;
            if (n_a !== last) seen.push_back(int'(n_a));
            if (busy_a) begin
                n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL ramp_early_done: got %b want 0", done_a); end
            end
        end
        n_cmp++; if (iters != 15) begin n_bad++; $display("FAIL ramp_cycles: got %0d want 15", iters); end
        n_cmp++; if (seen.size() != 4) begin n_bad++; $display("FAIL ramp_steps: got %0d want 4", seen.size()); end
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            n_cmp++; if (seen[i] != exp_v[i]) begin n_bad++; $display("FAIL ramp_seq[%0d]: got %0d want %0d", i, seen[i], exp_v[i]); end
        end
        n_cmp++; if (done_a !== 1'b1) begin n_bad++; $display("FAIL ramp_done: got %b want 1", done_a); end
        cycle(0, 0, 0, 0);
        n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL ramp_done_pulse: got %b want 0", done_a); end
    endtask

    task automatic test_ramp_wide();
        int exp_v[2] = '{'h0FF0, 'h0005};
        int seen[$];
        int iters;
        logic [14:0] last;
        do_reset();
        cycle(1, 1, 'h7FF0, 0);
        n_cmp++; if (n_b !== 15'h7FF0) begin n_bad++; $display("FAIL wide_set: got %0h want 7ff0", n_b); end
        cycle(1, 1, 'h0005, 1);
        iters = 0;
        while (busy_b && iters < 20) begin
            last = n_b;
            cycle(1, 0, 0, 0);
            iters++;
            if (n_b !== last) seen.push_back(int'(n_b));
        end
        n_cmp++; if (seen.size() != 2) begin n_bad++; $display("FAIL wide_steps: got %0d want 2", seen.size()); end
        for (int i = 0; i < 2 && i < seen.size(); i++) begin
            n_cmp++; if (seen[i] != exp_v[i]) begin n_bad++; $display("FAIL wide_seq[%0d]: got %0h want %0h", i, seen[i], exp_v[i]); end
        end
        n_cmp++; if (done_b !== 1'b1) begin n_bad++; $display("FAIL wide_done: got %b want 1", done_b); end
    endtask

    task automatic test_breathe();
        int exp_v[5] = '{10, 20, 10, 0, 10};
        int seen[$];
        logic [14:0] last;
        do_reset();
        cycle(0, 1, 20, 2);
        for (int i = 0; i < 40; i++) begin
            last = n_a;
            cycle(0, 0, 0, 0);
            if (n_a !== last) seen.push_back(int'(n_a));
            n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("FAIL br_busy: got %b want 1", busy_a); end
            n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL br_done: got %b want 0", done_a); end
        end
        n_cmp++; if (seen.size() < 5) begin n_bad++; $display("FAIL br_steps: got %0d want >=5", seen.size()); end
        for (int i = 0; i < 5 && i < seen.size(); i++) begin
            n_cmp++; if (seen[i] != exp_v[i]) begin n_bad++; $display("FAIL br_seq[%0d]: got %0d want %0d", i, seen[i], exp_v[i]); end
        end
        cycle(0, 1, 5, 0);
        n_cmp++; if (n_a !== 15'd5)   begin n_bad++; $display("FAIL br_set_value: got %0d want 5", n_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL br_set_idle: got %b want 0", busy_a); end
    endtask

    task automatic test_clamp();
        do_reset();
        cycle(2, 1, 'h7FFF, 0);
        n_cmp++; if (n_c !== 15'h1000) begin n_bad++; $display("FAIL clamp_set: got %0h want 1000", n_c); end
    endtask

    task automatic test_reserved();
        do_reset();
        cycle(0, 1, 30, 0);
        cycle(0, 1, 999, 3);
        n_cmp++; if (n_a !== 15'd30)  begin n_bad++; $display("FAIL rsv_value: got %0d want 30", n_a); end
        n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL rsv_done: got %b want 0", done_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rsv_busy: got %b want 0", busy_a); end
    endtask

    task automatic test_reset_mid_ramp();
        do_reset();
        cycle(0, 1, 35, 1);
        repeat (5) cycle(0, 0, 0, 0);
        n_cmp++; if (n_a !== 15'd10) begin n_bad++; $display("FAIL rmr_pre: got %0d want 10", n_a); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (n_a !== 15'd0)   begin n_bad++; $display("FAIL rmr_n_high: got %0d want 0", n_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rmr_busy: got %b want 0", busy_a); end
        n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL rmr_done: got %b want 0", done_a); end
        n_cmp++; if (ifa.cmd_ready !== 1'b1) begin n_bad++; $display("FAIL rmr_ready: got %b want 1", ifa.cmd_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(0, 1, 20, 1);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (n_a !== 15'd0 || done_a !== 1'b0) begin n_bad++; $display("FAIL rmr_restart[%0d]: got %0d/%b want 0/0", i, n_a, done_a); end
            if (i < 2) cycle(0, 0, 0, 0);
        end
        cycle(0, 0, 0, 0);
        n_cmp++; if (n_a !== 15'd10) begin n_bad++; $display("FAIL rmr_first_tick: got %0d want 10", n_a); end
    endtask

    task automatic test_random();
        bit v;
        int t, m;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 3) == 0);
            m = $urandom_range(0, 3);
            if (m == 0 && $urandom_range(0, 3) == 0) t = $urandom_range(0, 32767);
            else                                     t = $urandom_range(0, 120);
            // Keep ramps short: large levels are only left via SET.
            if (m == 1 && m_level > 200) m = 0;
            cycle(0, v, t, m);
            n_cmp++; if (int'(n_a) != m_level) begin n_bad++; $display("FAIL rnd_n_high @%0d: got %0d want %0d", i, n_a, m_level); end
            n_cmp++; if (busy_a !== (m_act != 0)) begin n_bad++; $display("FAIL rnd_busy @%0d: got %b want %b", i, busy_a, m_act != 0); end
            n_cmp++; if (done_a !== (m_done != 0)) begin n_bad++; $display("FAIL rnd_done @%0d: got %b want %b", i, done_a, m_done != 0); end
            n_cmp++; if (ifa.cmd_ready !== (m_act != 1)) begin n_bad++; $display("FAIL rnd_ready @%0d: got %b want %b", i, ifa.cmd_ready, m_act != 1); end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time budget");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_set();
        test_ramp();
        test_ramp_wide();
        test_breathe();
        test_clamp();
        test_reserved();
        test_reset_mid_ramp();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
